// File: rtl/traffic_light_monitor.sv
// Passive checker for the intersection light bus: verifies lamp encoding, mutual
// exclusion, phase order, dwell timing and liveness; reports faults and counts cycles.
module traffic_light_monitor #(
  parameter int GREEN_MIN   = 50000,
  parameter int GREEN_MAX   = 50002,
  parameter int YEL_MIN     = 10000,
  parameter int YEL_MAX     = 10002,
  parameter int WDOG_CYCLES = 60000,
  parameter int CNT_W       = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  ns_light,
  input  logic [2:0]  ew_light,
  input  logic        clr_fault,
  output logic        err_pulse,
  output logic        fault,
  output logic [3:0]  fault_code,
  output logic [7:0]  err_count,
  output logic [15:0] cycle_count
);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] G_MIN    = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] G_LONG   = CNT_W'(GREEN_MAX + 1);
  localparam logic [CNT_W-1:0] Y_MIN    = CNT_W'(YEL_MIN);
  localparam logic [CNT_W-1:0] Y_LONG   = CNT_W'(YEL_MAX + 1);
  localparam logic [CNT_W-1:0] WDOG_HIT = CNT_W'(WDOG_CYCLES);

  typedef enum logic [3:0] {
    FC_NONE, FC_ENC, FC_CONFLICT, FC_BAD_TRANS, FC_GREEN_SHORT,
    FC_GREEN_LONG, FC_YEL_SHORT, FC_YEL_LONG, FC_STALL
  } fault_e;

  logic [2:0]       prev_ns, prev_ew;
  logic [CNT_W-1:0] ns_dwell, ew_dwell, stall;
  logic             ns_armed, ns_timed, ew_armed, ew_timed;

  logic             enc, ns_chg, ew_chg, any_viol;
  logic [CNT_W-1:0] ns_dwell_nxt, ew_dwell_nxt, stall_nxt;
  logic [8:1]       viol;
  logic [3:0]       code;

  function automatic logic lamp_ok(input logic [2:0] c);
    return (c == RED) || (c == YEL) || (c == GRN);
  endfunction

  function automatic logic legal_move(input logic [2:0] p, input logic [2:0] c);
    return (p == c) || (p == RED && c == GRN) || (p == GRN && c == YEL) || (p == YEL && c == RED);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    viol         = '0;
    code         = FC_NONE;
    enc          = !lamp_ok(ns_light) || !lamp_ok(ew_light);
    ns_chg       = ns_light != prev_ns;
    ew_chg       = ew_light != prev_ew;
    ns_dwell_nxt = ns_chg ? CNT_W'(1) : sat_inc(ns_dwell);
    ew_dwell_nxt = ew_chg ? CNT_W'(1) : sat_inc(ew_dwell);
    stall_nxt    = (!enc && (ns_chg || ew_chg)) ? '0 : sat_inc(stall);

    viol[FC_ENC] = enc;
    // A malformed sample says nothing trustworthy about order or timing.
    if (!enc) begin
      viol[FC_CONFLICT]    = (ns_light != RED) && (ew_light != RED);
      viol[FC_BAD_TRANS]   = !legal_move(prev_ns, ns_light) || !legal_move(prev_ew, ew_light) ||
                             (prev_ns == RED && ns_light == GRN && ew_light != RED) ||
                             (prev_ew == RED && ew_light == GRN && ns_light != RED);
      viol[FC_GREEN_SHORT] = (prev_ns == GRN && ns_light == YEL && ns_dwell < G_MIN && ns_timed) ||
                             (prev_ew == GRN && ew_light == YEL && ew_dwell < G_MIN && ew_timed);
      viol[FC_GREEN_LONG]  = (ns_light == GRN && ns_dwell_nxt == G_LONG && !ns_chg) ||
                             (ew_light == GRN && ew_dwell_nxt == G_LONG && !ew_chg);
      viol[FC_YEL_SHORT]   = (prev_ns == YEL && ns_light == RED && ns_dwell < Y_MIN && ns_timed) ||
                             (prev_ew == YEL && ew_light == RED && ew_dwell < Y_MIN && ew_timed);
      viol[FC_YEL_LONG]    = (ns_light == YEL && ns_dwell_nxt == Y_LONG && !ns_chg) ||
                             (ew_light == YEL && ew_dwell_nxt == Y_LONG && !ew_chg);
      viol[FC_STALL]       = stall_nxt == WDOG_HIT;
    end

    any_viol = |viol;
    for (int i = 8; i >= 1; i--) begin
      if (viol[i]) code = 4'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_ns     <= RED;
      prev_ew     <= RED;
      ns_dwell    <= '0;
      ew_dwell    <= '0;
      stall       <= '0;
      ns_armed    <= 1'b0;
      ns_timed    <= 1'b0;
      ew_armed    <= 1'b0;
      ew_timed    <= 1'b0;
      err_pulse   <= 1'b0;
      fault       <= 1'b0;
      fault_code  <= '0;
      err_count   <= '0;
      cycle_count <= '0;
    end else begin
      // NOTE: non-blocking so every register sees the pre-edge values of the others.
      stall     <= stall_nxt;
      err_pulse <= any_viol;

      if (!enc) begin
        prev_ns  <= ns_light;
        prev_ew  <= ew_light;
        ns_dwell <= ns_dwell_nxt;
        ew_dwell <= ew_dwell_nxt;
        if (ns_chg) begin
          ns_timed <= ns_armed;
          ns_armed <= 1'b1;
        end
        if (ew_chg) begin
          ew_timed <= ew_armed;
          ew_armed <= 1'b1;
        end
        if (prev_ew == YEL && ew_light == RED) cycle_count <= cycle_count + 16'd1;
      end

      // A violation coinciding with a clear is latched as the new first fault.
      if (clr_fault) begin
        fault      <= any_viol;
        fault_code <= any_viol ? code : 4'd0;
        err_count  <= any_viol ? 8'd1 : 8'd0;
      end else if (any_viol) begin
        fault <= 1'b1;
        if (!fault) fault_code <= code;
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor using shortened timing parameters;
// each scenario task drives samples and compares outputs against hand-computed values.
module tb_traffic_light_monitor;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr_fault;
  logic [2:0]  ns_light;
  logic [2:0]  ew_light;
  logic        err_pulse;
  logic        fault;
  logic [3:0]  fault_code;
  logic [7:0]  err_count;
  logic [15:0] cycle_count;

  int tests_run    = 0;
  int tests_failed = 0;
  int pulse_cnt    = 0;

  traffic_light_monitor #(
    .GREEN_MIN(8), .GREEN_MAX(10), .YEL_MIN(3), .YEL_MAX(4), .WDOG_CYCLES(20), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .ns_light(ns_light), .ew_light(ew_light), .clr_fault(clr_fault),
    .err_pulse(err_pulse), .fault(fault), .fault_code(fault_code),
    .err_count(err_count), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // One sample: inputs settle mid-cycle, outputs are read 1 ns after the capturing edge.
  task automatic step(input logic [2:0] ns, input logic [2:0] ew);
    ns_light = ns;
    ew_light = ew;
    @(posedge clk);
    #1;
  endtask

  task automatic phase(input logic [2:0] ns, input logic [2:0] ew, input int n);
    for (int i = 0; i < n; i++) begin
      step(ns, ew);
      if (err_pulse === 1'b1) pulse_cnt++;
    end
  endtask

  task automatic one_cycle();
    phase(G, R, 9);
    phase(Y, R, 4);
    phase(R, G, 9);
    phase(R, Y, 4);
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    clr_fault = 1'b0;
    ns_light  = R;
    ew_light  = R;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++; if (err_pulse !== 1'b0) begin tests_failed++; $display("FAIL reset_err_pulse got=%b want=0", err_pulse); end
    tests_run++; if (fault !== 1'b0) begin tests_failed++; $display("FAIL reset_fault got=%b want=0", fault); end
    tests_run++; if (fault_code !== 4'd0) begin tests_failed++; $display("FAIL reset_fault_code got=%0d want=0", fault_code); end
    tests_run++; if (err_count !== 8'd0) begin tests_failed++; $display("FAIL reset_err_count got=%0d want=0", err_count); end
    tests_run++; if (cycle_count !== 16'd0) begin tests_failed++; $display("FAIL reset_cycle_count got=%0d want=0", cycle_count); end
  endtask

  task automatic test_normal();
    apply_reset();
    pulse_cnt = 0;
    for (int c = 0; c < 3; c++) one_cycle();
    phase(R, R, 1);
    tests_run++; if (pulse_cnt !== 0) begin tests_failed++; $display("FAIL normal_pulses got=%0d want=0", pulse_cnt); end
    tests_run++; if (fault !== 1'b0) begin tests_failed++; $display("FAIL normal_fault got=%b want=0", fault); end
    tests_run++; if (err_count !== 8'd0) begin tests_failed++; $display("FAIL normal_err_count got=%0d want=0", err_count); end
    tests_run++; if (cycle_count !== 16'd3) begin tests_failed++; $display("FAIL normal_cycle_count got=%0d want=3", cycle_count); end
  endtask

  task automatic test_conflict();
    apply_reset();
    phase(G, R, 3);
    tests_run++; if (err_pulse !== 1'b0) begin tests_failed++; $display("FAIL conflict_pre_pulse got=%b want=0", err_pulse); end
    step(G, Y);
    tests_run++; if (err_pulse !== 1'b1) begin tests_failed++; $display("FAIL conflict_pulse got=%b want=1", err_pulse); end
    tests_run++; if (fault !== 1'b1) begin tests_failed++; $display("FAIL conflict_fault got=%b want=1", fault); end
    tests_run++; if (fault_code !== 4'd2) begin tests_failed++; $display("FAIL conflict_code got=%0d want=2", fault_code); end
    tests_run++; if (err_count !== 8'd1) begin tests_failed++; $display("FAIL conflict_err_count got=%0d want=1", err_count); end
    step(G, R);
    tests_run++; if (err_pulse !== 1'b0) begin tests_failed++; $display("FAIL conflict_post_pulse got=%b want=0", err_pulse); end
    tests_run++; if (fault !== 1'b1) begin tests_failed++; $display("FAIL conflict_sticky got=%b want=1", fault); end
    tests_run++; if (cycle_count !== 16'd1) begin tests_failed++; $display("FAIL conflict_cycle_count got=%0d want=1", cycle_count); end
  endtask

  task automatic test_timing();
    apply_reset();
    one_cycle();
    phase(G, R, 5);
    step(Y, R);
    tests_run++; if (err_pulse !== 1'b1) begin tests_failed++; $display("FAIL gshort_pulse got=%b want=1", err_pulse); end
    tests_run++; if (fault_code !== 4'd4) begin tests_failed++; $display("FAIL gshort_code got=%0d want=4", fault_code); end
    tests_run++; if (err_count !== 8'd1) begin tests_failed++; $display("FAIL gshort_err_count got=%0d want=1", err_count); end
    clr_fault = 1'b1;
    step(Y, R);
    clr_fault = 1'b0;
    tests_run++; if (fault !== 1'b0) begin tests_failed++; $display("FAIL clr_fault got=%b want=0", fault); end
    tests_run++; if (fault_code !== 4'd0) begin tests_failed++; $display("FAIL clr_code got=%0d want=0", fault_code); end
    tests_run++; if (err_count !== 8'd0) begin tests_failed++; $display("FAIL clr_err_count got=%0d want=0", err_count); end
    phase(Y, R, 2);
    phase(R, G, 9);
    for (int i = 0; i < 6; i++) begin
      step(R, Y);
      tests_run++;
      if (err_pulse !== (i == 4)) begin
        tests_failed++;
        $display("FAIL ylong_pulse sample=%0d got=%b want=%b", i + 1, err_pulse, (i == 4));
      end
    end
    tests_run++; if (fault_code !== 4'd7) begin tests_failed++; $display("FAIL ylong_code got=%0d want=7", fault_code); end
    tests_run++; if (err_count !== 8'd1) begin tests_failed++; $display("FAIL ylong_err_count got=%0d want=1", err_count); end
  endtask

  task automatic test_bad_trans();
    apply_reset();
    phase(G, R, 3);
    step(R, R);
    tests_run++; if (err_pulse !== 1'b1) begin tests_failed++; $display("FAIL badtr_pulse got=%b want=1", err_pulse); end
    tests_run++; if (fault_code !== 4'd3) begin tests_failed++; $display("FAIL badtr_code got=%0d want=3", fault_code); end
    tests_run++; if (err_count !== 8'd1) begin tests_failed++; $display("FAIL badtr_err_count got=%0d want=1", err_count); end
    apply_reset();
    phase(G, R, 3);
    step(R, 3'b110);
    tests_run++; if (err_pulse !== 1'b1) begin tests_failed++; $display("FAIL enc_pulse got=%b want=1", err_pulse); end
    tests_run++; if (fault_code !== 4'd1) begin tests_failed++; $display("FAIL enc_code got=%0d want=1", fault_code); end
    tests_run++; if (err_count !== 8'd1) begin tests_failed++; $display("FAIL enc_err_count got=%0d want=1", err_count); end
    // State held across the bad sample, so continuing green/red is clean.
    step(G, R);
    tests_run++; if (err_pulse !== 1'b0) begin tests_failed++; $display("FAIL enc_hold_pulse got=%b want=0", err_pulse); end
    tests_run++; if (err_count !== 8'd1) begin tests_failed++; $display("FAIL enc_hold_err_count got=%0d want=1", err_count); end
  endtask

  task automatic test_stall();
    apply_reset();
    for (int i = 0; i < 25; i++) begin
      step(R, R);
      tests_run++;
      if (err_pulse !== (i == 19)) begin
        tests_failed++;
        $display("FAIL stall_pulse sample=%0d got=%b want=%b", i + 1, err_pulse, (i == 19));
      end
    end
    tests_run++; if (fault_code !== 4'd8) begin tests_failed++; $display("FAIL stall_code got=%0d want=8", fault_code); end
    for (int i = 0; i < 21; i++) begin
      step(G, R);
      tests_run++;
      if (err_pulse !== (i == 10 || i == 20)) begin
        tests_failed++;
        $display("FAIL rearm_pulse sample=%0d got=%b want=%b", i + 1, err_pulse, (i == 10 || i == 20));
      end
    end
    tests_run++; if (err_count !== 8'd3) begin tests_failed++; $display("FAIL rearm_err_count got=%0d want=3", err_count); end
    tests_run++; if (fault_code !== 4'd8) begin tests_failed++; $display("FAIL rearm_code got=%0d want=8", fault_code); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    one_cycle();
    phase(G, R, 5);
    rst = 1'b1;
    step(G, R);
    rst = 1'b0;
    tests_run++; if (cycle_count !== 16'd0) begin tests_failed++; $display("FAIL midrst_cycle_count got=%0d want=0", cycle_count); end
    phase(G, R, 4);
    step(Y, R);
    tests_run++; if (err_pulse !== 1'b0) begin tests_failed++; $display("FAIL midrst_pulse got=%b want=0", err_pulse); end
    tests_run++; if (fault !== 1'b0) begin tests_failed++; $display("FAIL midrst_fault got=%b want=0", fault); end
    tests_run++; if (err_count !== 8'd0) begin tests_failed++; $display("FAIL midrst_err_count got=%0d want=0", err_count); end
  endtask

  task automatic test_clr_conflict();
    apply_reset();
    phase(G, R, 2);
    step(R, R);
    tests_run++; if (fault_code !== 4'd3) begin tests_failed++; $display("FAIL clrc_pre_code got=%0d want=3", fault_code); end
    step(G, R);
    clr_fault = 1'b1;
    step(G, Y);
    clr_fault = 1'b0;
    tests_run++; if (fault !== 1'b1) begin tests_failed++; $display("FAIL clrc_fault got=%b want=1", fault); end
    tests_run++; if (fault_code !== 4'd2) begin tests_failed++; $display("FAIL clrc_code got=%0d want=2", fault_code); end
    tests_run++; if (err_count !== 8'd1) begin tests_failed++; $display("FAIL clrc_err_count got=%0d want=1", err_count); end
  endtask

  task automatic test_saturation();
    apply_reset();
    for (int i = 0; i < 260; i++) step(3'b111, R);
    tests_run++; if (err_count !== 8'd255) begin tests_failed++; $display("FAIL sat_err_count got=%0d want=255", err_count); end
    tests_run++; if (fault_code !== 4'd1) begin tests_failed++; $display("FAIL sat_code got=%0d want=1", fault_code); end
  endtask

  initial begin
    rst       = 1'b1;
    clr_fault = 1'b0;
    ns_light  = R;
    ew_light  = R;
    test_reset();
    test_normal();
    test_conflict();
    test_timing();
    test_bad_trans();
    test_stall();
    test_reset_mid();
    test_clr_conflict();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within 200000 ns");
    $fatal(1);
  end

endmodule
